// File: rtl/stream_demux_4.sv
// stream_demux_4 -- registered 1-to-4 valid/ready demultiplexer.
//
// One producer stream is steered by in_sel into one of four output channels.
// Each channel is a single holding register with its own valid/ready
// handshake. A channel that is draining in the same cycle can accept a new
// word, so a channel whose consumer keeps out_ready high takes one word per
// cycle with no bubble.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   reset      synchronous, active-high reset
//   in_data    input data word (WIDTH bits)
//   in_sel     destination channel (0=a, 1=b, 2=c, 3=d)
//   in_valid   producer has a word
//   in_ready   the channel addressed by in_sel can take a word this cycle
//   out_data   channel k data at bits [k*WIDTH +: WIDTH]
//   out_valid  channel k holds a word
//   out_ready  consumer k accepts the held word
//   out_count  (only with STREAM_DEMUX_4_COUNT_EN) four saturating 8-bit
//              drain counters, channel k at bits [k*8 +: 8]
//
// Optional feature macro: STREAM_DEMUX_4_COUNT_EN adds out_count and its
// counters. The datapath is identical in both builds.

module stream_demux_4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready
`ifdef STREAM_DEMUX_4_COUNT_EN
  ,
  output logic [31:0]        out_count
`endif
);

  logic       acc;
  logic [3:0] load;
  logic [3:0] drain;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    load     = '0;
    // A full channel can still accept when it is draining this cycle.
    in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    acc      = in_valid & in_ready;
    drain    = out_valid & out_ready;
    if (acc) begin
      load[in_sel] = 1'b1;
    end
  end

  // Per-channel holding register. The valid bit is the whole channel state:
  // EMPTY->FULL on load, FULL->EMPTY on drain without load, FULL->FULL on
  // load+drain (the new word overwrites the one leaving).
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the data registers are reset too, because out_data must read
      // zero after reset; otherwise a datapath register needs no reset.
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        // NOTE: non-blocking assignments for all sequential state, so every
        // register samples pre-edge values regardless of statement order.
        if (load[k]) begin
          out_data[k*WIDTH +: WIDTH] <= in_data;
          out_valid[k]               <= 1'b1;
        end else if (drain[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

`ifdef STREAM_DEMUX_4_COUNT_EN
  logic [3:0][7:0] cnt;

  // Drain counters stick at 255 instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (drain[k] && (cnt[k] != 8'hFF)) begin
          cnt[k] <= cnt[k] + 8'd1;
        end
      end
    end
  end

  assign out_count = cnt;
`endif

endmodule

// File: tb/tb_stream_demux_4.sv
// tb_stream_demux_4 -- scoreboard bench for stream_demux_4.
//
// The reference model is one FIFO of expected words per channel: a channel is
// full exactly when its queue is non-empty. The stimulus process pushes each
// word the model says is accepted; a separate monitor compares every channel
// against its queue head each cycle and pops on a consumer handshake.

module tb_stream_demux_4;

  localparam int W = 8;
  typedef logic [W-1:0] word_t;

  logic           clk = 1'b0;
  logic           reset;
  word_t          in_data;
  logic [1:0]     in_sel;
  logic           in_valid;
  logic           in_ready;
  logic [4*W-1:0] out_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
`ifdef STREAM_DEMUX_4_COUNT_EN
  logic [31:0]    out_count;
`endif

  stream_demux_4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef STREAM_DEMUX_4_COUNT_EN
    ,
    .out_count (out_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state.
  word_t expq [4][$];
  word_t last_data [4];
  int    drains [4];
  logic  mon_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int sat255(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  // Monitor: after the stimulus has settled, compare every channel with the
  // model and retire the words drained at the coming edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        for (int k = 0; k < 4; k++) begin
          check($sformatf("out_valid[%0d]", k), 32'(out_valid[k]),
                32'(expq[k].size() != 0));
          if (expq[k].size() != 0) begin
            check($sformatf("out_data[%0d]", k), 32'(out_data[k*W +: W]),
                  32'(expq[k][0]));
            if (out_ready[k]) begin
              void'(expq[k].pop_front());
              drains[k]++;
            end
          end else begin
            check($sformatf("out_data_hold[%0d]", k), 32'(out_data[k*W +: W]),
                  32'(last_data[k]));
          end
        end
      end
    end
  end

  // One producer cycle: drive, check in_ready against the model, and record
  // the word in the model once the edge that accepts it has passed.
  task automatic cycle(input logic v, input logic [1:0] s, input word_t d,
                       input logic [3:0] ordy, output logic accepted);
    logic exp_rdy;
    @(negedge clk);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = ordy;
    #1;
    exp_rdy = (expq[s].size() == 0) || ordy[s];
    check($sformatf("in_ready(sel=%0d)", s), 32'(in_ready), 32'(exp_rdy));
    accepted = v && exp_rdy;
    @(posedge clk);
    #1;
    if (accepted) begin
      expq[s].push_back(d);
      last_data[s] = d;
    end
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, '0, 4'hF, a);
  endtask

  // Reset with in_valid held high; while reset is still asserted, every
  // channel must read empty/zero and in_ready must be 1 for every in_sel.
  task automatic apply_reset(input int n);
    @(negedge clk);
    mon_en   = 1'b0;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    repeat (n) @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      expq[k].delete();
      last_data[k] = '0;
      drains[k]    = 0;
    end
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset out_data", out_data, 32'h0);
`ifdef STREAM_DEMUX_4_COUNT_EN
    check("reset out_count", out_count, 32'h0);
`endif
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      check($sformatf("reset in_ready(sel=%0d)", s), 32'(in_ready), 32'h1);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    mon_en   = 1'b1;
  endtask

  initial begin
    logic  a;
    logic  pend;
    logic  v;
    logic [1:0] s;
    word_t d;
    word_t route [4];

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = '0;
    out_ready = 4'h0;
    for (int k = 0; k < 4; k++) begin
      last_data[k] = '0;
      drains[k]    = 0;
    end

    apply_reset(2);

    // Routing: one word per channel on consecutive cycles.
    route[0] = 8'hA0; route[1] = 8'hB1; route[2] = 8'hC2; route[3] = 8'hD3;
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'(i), route[i], 4'hF, a);
    idle(2);

    // Backpressure on channel c, then simultaneous drain and reload.
    cycle(1'b1, 2'd2, 8'h11, 4'b1011, a);
    cycle(1'b1, 2'd2, 8'h22, 4'b1011, a);
    cycle(1'b1, 2'd2, 8'h22, 4'b1011, a);
    cycle(1'b1, 2'd2, 8'h22, 4'b1111, a);
    idle(2);

    // Independence: channel a stalled full, channel d still accepts.
    cycle(1'b1, 2'd0, 8'h5A, 4'b0000, a);
    cycle(1'b1, 2'd3, 8'h77, 4'b0000, a);
    cycle(1'b1, 2'd0, 8'h66, 4'b0000, a);
    idle(2);

    // Reset mid-operation discards held words on b and d.
    cycle(1'b1, 2'd1, 8'h33, 4'b0000, a);
    cycle(1'b1, 2'd3, 8'h44, 4'b0000, a);
    apply_reset(1);
    cycle(1'b1, 2'd1, 8'h55, 4'b0000, a);
    idle(2);

    // Random traffic; a word not accepted is held stable until it is.
    pend = 1'b0;
    v = 1'b0; s = 2'd0; d = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!pend) begin
        v = ($urandom_range(0, 3) != 0);
        s = 2'($urandom_range(0, 3));
        d = word_t'($urandom);
      end
      cycle(v, s, d, 4'($urandom), a);
      pend = v && !a;
    end
    idle(3);
`ifdef STREAM_DEMUX_4_COUNT_EN
    @(negedge clk); #1;
    check("random out_count", out_count,
          {8'(sat255(drains[3])), 8'(sat255(drains[2])),
           8'(sat255(drains[1])), 8'(sat255(drains[0]))});
`endif

    // Saturation: 300 back-to-back words to channel a.
    apply_reset(1);
    for (int i = 0; i < 300; i++) cycle(1'b1, 2'd0, word_t'(i), 4'hF, a);
    idle(3);
`ifdef STREAM_DEMUX_4_COUNT_EN
    @(negedge clk); #1;
    check("saturated out_count", out_count, 32'h0000_00FF);
    check("model out_count", out_count,
          {8'(sat255(drains[3])), 8'(sat255(drains[2])),
           8'(sat255(drains[1])), 8'(sat255(drains[0]))});
`endif
    check("drained words ch a", 32'(drains[0]), 32'd300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
